// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, reads the synchronous
// instruction memory (one-cycle latency) and hands each word with its PC to
// the decoder over a valid/ready handshake. Supports redirect and halts once
// an EBREAK has been consumed.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              halted,
    output logic [31:0]       retired
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic [31:0] retired_q, retired_d;

    logic        handshake;
    logic [31:0] redirect_target;

    assign handshake       = (state_q == S_VALID) && instr_ready;
    assign redirect_target = redirect_pc & ~32'h0000_0003;

    // Memory request: issued from FETCH, or overlapped with a non-EBREAK handshake.
    always_comb begin
        imem_en   = 1'b0;
        imem_addr = fetch_pc_q[ADDR_W+1:2];
        if (rst_n) begin
            if (state_q == S_FETCH) begin
                imem_en = 1'b1;
            end else if (handshake && (instr_q != EBREAK)) begin
                imem_en = 1'b1;
            end
        end
    end

    // Next-state logic; redirect overrides everything except retirement of a
    // handshake completing in the same cycle.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        retired_d     = retired_q;

        if (handshake) begin
            retired_d = retired_q + 32'd1;
        end

        if (redirect) begin
            state_d       = S_FETCH;
            fetch_pc_d    = redirect_target;
            instr_valid_d = 1'b0;
            halted_d      = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 32'd4;
                    instr_valid_d = 1'b1;
                    state_d       = S_VALID;
                end
                S_VALID: begin
                    if (handshake) begin
                        instr_valid_d = 1'b0;
                        if (instr_q == EBREAK) begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            fetch_pc_q    <= RESET_PC;
            instr_q       <= NOP;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            retired_q     <= retired_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: memory model, scoreboard of expected
// {pc, word} pairs popped on each handshake, and per-scenario tasks.
module tb_instr_fetch;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;

    // Main DUT (RESET_PC = 0)
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr, instr_pc, retired;
    logic        instr_valid, instr_ready, redirect, halted;
    logic [31:0] redirect_pc;

    // Wrap DUT (RESET_PC = 0xFFFF_FFFC)
    logic        w_imem_en;
    logic [9:0]  w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic [31:0] w_instr, w_instr_pc, w_retired;
    logic        w_instr_valid, w_instr_ready, w_redirect, w_halted;
    logic [31:0] w_redirect_pc;

    logic [31:0] mem [0:1023];
    logic [63:0] exp_q [$];
    int          n_tests;
    int          n_fail;

    instr_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted), .retired(retired)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(10)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_en(w_imem_en), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .halted(w_halted), .retired(w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory models, one-cycle read latency
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem[imem_addr];
        if (w_imem_en) w_imem_rdata <= mem[w_imem_addr];
    end

    // Scoreboard: every handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no handshake", instr_pc, instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({instr_pc, instr} !== e) begin
                    n_fail++;
                    $display("FAIL sb_handshake: got pc=%h instr=%h, required pc=%h instr=%h",
                             instr_pc, instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, mem[pc[11:2]]});
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({instr_valid, halted, imem_en} !== 3'b000 || instr !== NOP || instr_pc !== 32'h0 || retired !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: got v=%b h=%b en=%b instr=%h pc=%h ret=%0d, required 0 0 0 %h 0 0",
                     instr_valid, halted, imem_en, instr, instr_pc, retired, NOP);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (imem_en !== 1'b1 || imem_addr !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_fetch: got en=%b addr=%h, required 1 000", imem_en, imem_addr);
        end
    endtask

    task automatic test_stream();
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) push_exp(32'(k * 4));
        for (int n = 1; n <= 16; n++) begin
            tick();
            n_tests++;
            if (instr_valid !== ((n % 2) == 0)) begin
                n_fail++;
                $display("FAIL stream_cadence: cycle %0d got valid=%b, required %b", n, instr_valid, (n % 2) == 0);
            end
        end
        tick();
        instr_ready = 1'b0;
        n_tests++;
        if (retired !== 32'd8 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_retired: got %0d (pending %0d), required 8 (pending 0)", retired, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'd32 || instr !== mem[8] || imem_en !== 1'b0 || retired !== 32'd8) begin
                n_fail++;
                $display("FAIL bp_hold: got v=%b pc=%h instr=%h en=%b ret=%0d, required 1 20 %h 0 8",
                         instr_valid, instr_pc, instr, imem_en, retired, mem[8]);
            end
            if (i < 4) tick();
        end
        push_exp(32'd32);
        instr_ready = 1'b1;
        #1;
        n_tests++;
        if (imem_en !== 1'b1 || imem_addr !== 10'd9) begin
            n_fail++;
            $display("FAIL bp_overlap: got en=%b addr=%h, required 1 009", imem_en, imem_addr);
        end
        tick();
        instr_ready = 1'b0;
        n_tests++;
        if (retired !== 32'd9 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_resume_retire: got ret=%0d v=%b, required 9 0", retired, instr_valid);
        end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'd36 || instr !== mem[9]) begin
            n_fail++;
            $display("FAIL bp_resume_addr: got v=%b pc=%h instr=%h, required 1 24 %h", instr_valid, instr_pc, instr, mem[9]);
        end
    endtask

    task automatic test_redirect();
        push_exp(32'd36);
        instr_ready = 1'b1;
        tick();                                  // handshake pc 36, now WAIT
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();                                  // redirect edge N
        redirect = 1'b0;
        n_tests++;
        if (instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'h040 || retired !== 32'd10) begin
            n_fail++;
            $display("FAIL redir_fetch: got v=%b en=%b addr=%h ret=%0d, required 0 1 040 10",
                     instr_valid, imem_en, imem_addr, retired);
        end
        push_exp(32'h100);
        tick();
        n_tests++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_n1: got v=%b, required 0", instr_valid);
        end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem[64]) begin
            n_fail++;
            $display("FAIL redir_n2: got v=%b pc=%h instr=%h, required 1 100 %h", instr_valid, instr_pc, instr, mem[64]);
        end
        tick();                                  // handshake pc 0x100
        push_exp(32'h104);
        tick();                                  // VALID pc 0x104
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        n_tests++;
        if (imem_en !== 1'b1 || imem_addr !== 10'h042) begin
            n_fail++;
            $display("FAIL redir_hs_overlap: got en=%b addr=%h, required 1 042", imem_en, imem_addr);
        end
        tick();
        redirect = 1'b0;
        n_tests++;
        if (retired !== 32'd12 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_hs_retire: got ret=%0d v=%b, required 12 0", retired, instr_valid);
        end
        push_exp(32'h200);
        tick();
        tick();
        tick();
        instr_ready = 1'b0;
        n_tests++;
        if (retired !== 32'd13 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL redir_target: got ret=%0d (pending %0d), required 13 (pending 0)", retired, exp_q.size());
        end
    endtask

    task automatic test_ebreak();
        mem[2] = EBREAK;
        pulse_reset();
        push_exp(32'd0);
        push_exp(32'd4);
        push_exp(32'd8);
        instr_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_en !== 1'b0 || retired !== 32'd3) begin
                n_fail++;
                $display("FAIL ebreak_halt: got h=%b v=%b en=%b ret=%0d, required 1 0 0 3",
                         halted, instr_valid, imem_en, retired);
            end
            tick();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        n_tests++;
        if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'h0) begin
            n_fail++;
            $display("FAIL ebreak_restart: got h=%b en=%b addr=%h, required 0 1 000", halted, imem_en, imem_addr);
        end
        push_exp(32'd0);
        tick();
        tick();
        tick();
        instr_ready = 1'b0;
        n_tests++;
        if (retired !== 32'd4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ebreak_resume: got ret=%0d (pending %0d), required 4 (pending 0)", retired, exp_q.size());
        end
        mem[2] = NOP | (32'd2 << 20);
    endtask

    task automatic test_async_reset();
        tick();                                  // VALID, pc 4, ready low
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (instr_valid !== 1'b0 || retired !== 32'd0 || instr !== NOP || instr_pc !== 32'h0 || imem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b ret=%0d instr=%h pc=%h en=%b, required 0 0 %h 0 0",
                     instr_valid, retired, instr, instr_pc, imem_en, NOP);
        end
        #1;
        rst_n = 1'b1;
        push_exp(32'd0);
        instr_ready = 1'b1;
        tick();
        tick();
        tick();
        instr_ready = 1'b0;
        n_tests++;
        if (retired !== 32'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL async_restart: got ret=%0d (pending %0d), required 1 (pending 0)", retired, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        n_tests++;
        if (w_imem_en !== 1'b1 || w_imem_addr !== 10'h3FF) begin
            n_fail++;
            $display("FAIL wrap_first_addr: got en=%b addr=%h, required 1 3ff", w_imem_en, w_imem_addr);
        end
        tick();
        tick();
        n_tests++;
        if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr !== mem[1023]) begin
            n_fail++;
            $display("FAIL wrap_first: got v=%b pc=%h instr=%h, required 1 fffffffc %h",
                     w_instr_valid, w_instr_pc, w_instr, mem[1023]);
        end
        w_instr_ready = 1'b1;
        #1;
        n_tests++;
        if (w_imem_en !== 1'b1 || w_imem_addr !== 10'h000) begin
            n_fail++;
            $display("FAIL wrap_next_addr: got en=%b addr=%h, required 1 000", w_imem_en, w_imem_addr);
        end
        tick();
        w_instr_ready = 1'b0;
        tick();
        n_tests++;
        if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'h0 || w_instr !== mem[0] || w_retired !== 32'd1) begin
            n_fail++;
            $display("FAIL wrap_next: got v=%b pc=%h instr=%h ret=%0d, required 1 0 %h 1",
                     w_instr_valid, w_instr_pc, w_instr, w_retired, mem[0]);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        w_instr_ready = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        for (int unsigned k = 0; k < 1024; k++) mem[k] = NOP | (k << 20);

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_ebreak();
        test_async_reset();
        test_wrap();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle-issue RISC-V core. It holds the program counter and reads 32-bit words from a synchronous instruction memory with one-cycle read latency. It presents each word, with its PC, to the instruction decoder and execute stage through a valid/ready handshake. It also supports PC redirect and halts after an EBREAK has been consumed.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 10, word-address width of the instruction memory.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_en  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2].
- imem_rdata  in  32  read data, valid the cycle after imem_en.
- instr  out  32  instruction word presented downstream.
- instr_pc  out  32  byte address of instr.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr_ready  in  1  downstream consumes instr this cycle.
- redirect  in  1  load a new PC and flush.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced to 0).
- halted  out  1  EBREAK consumed; fetch stopped.
- retired  out  32  count of completed handshakes.

## Operation
- Internal fetch_pc is the address of the next word to request.
- FSM states: FETCH, WAIT, VALID, HALT.
- FETCH:
  - imem_en=1 and imem_addr=fetch_pc[ADDR_W+1:2].
  - Next state WAIT.
- WAIT:
  - imem_rdata is valid.
  - At the clock edge: instr<=imem_rdata, instr_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - Next state VALID.
- VALID:
  - instr_valid=1.
  - Handshake is instr_valid & instr_ready. On a handshake, retired increments by 1.
  - Handshake and instr==32'h0010_0073 (EBREAK): next state HALT, no new request.
  - Handshake with any other instruction: overlap the next request in the same cycle (imem_en=1, addr=fetch_pc[ADDR_W+1:2]); next state WAIT.
  - No handshake: hold instr, instr_pc and instr_valid stable; no request.
- HALT:
  - halted=1, instr_valid=0, imem_en=0.
  - Exits only on reset or redirect.
- Redirect has priority over every other event, in every state:
  - At the edge: fetch_pc<={redirect_pc[31:2],2'b00} and next state FETCH.
  - instr_valid is 0 from the next cycle; halted clears.
  - Read data in flight (state WAIT) is discarded.
  - If a handshake occurs in the same cycle as the redirect, the instruction is retired (counter increments), but the overlapped imem_en is still asserted and its data discarded.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- imem_addr wraps naturally within 2^ADDR_W words.
- retired wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - State FETCH, fetch_pc=RESET_PC.
  - instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0.
  - halted=0, retired=0.
  - imem_en=1 combinationally from FETCH while rst_n is high. imem_en=0 while rst_n is low.
- First instruction: instr_valid rises on the 2nd rising edge after rst_n deasserts (edge 1 leaves FETCH, edge 2 leaves WAIT).
- With instr_ready held at 1: one instruction every 2 cycles (VALID, WAIT, VALID, ...).
- imem_en and imem_addr are combinational from state, fetch_pc and instr_ready.
- All other outputs are registered.
- After redirect at edge N: imem_en is asserted in cycle N (state FETCH); the new instr_valid rises at edge N+2.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous); pending reads are dropped.

## Test plan
- Reset and stream:
  - Stimulus: imem word k = 32'h0000_0013 | (k<<20), instr_ready=1.
  - Required: instr_pc sequence 0,4,8,...; instr matches memory; valid every 2nd cycle; retired=8 after 8 handshakes.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles while valid.
  - Required: instr/instr_pc stable; imem_en=0 throughout; no retired change. Resumes at the next address once instr_ready rises.
- Redirect:
  - Stimulus: redirect_pc=32'h0000_0103 asserted during WAIT.
  - Required: in-flight word dropped; next instr_pc=32'h100, with instr_valid 2 cycles after the redirect edge.
- EBREAK:
  - Stimulus: word at 0x8 = 32'h0010_0073.
  - Required: after it is consumed, halted=1, imem_en stays 0, retired=3. A subsequent redirect to 0 restarts fetch and clears halted.
- Wrap:
  - Stimulus: RESET_PC=32'hFFFF_FFFC, ADDR_W=10.
  - Required: first instr_pc=32'hFFFF_FFFC with imem_addr=10'h3FF; next instr_pc=0 with imem_addr=0.
- Async reset mid-stream:
  - Stimulus: rst_n pulsed low between edges while in VALID.
  - Required: instr_valid=0, retired=0, instr=32'h0000_0013 immediately; fetch restarts from RESET_PC.
